// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between ALU/branch and writeback; word load/store over a req/ack bus.
// Optional ack timeout with a bus_error pulse is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter logic [4:0]  OP_LW          = 5'd20,
  parameter logic [4:0]  OP_SW          = 5'd21,
  parameter int unsigned TIMEOUT_CYCLES = 32'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_alu_result,
  input  logic        in_dest_enable,
  input  logic [4:0]  in_dest_reg,
  input  logic [4:0]  in_operation,
  input  logic [31:0] in_store_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wb_value,
  output logic        wb_enable,
  output logic [4:0]  wb_reg,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_done;
  logic        r_lat_en;
  logic [4:0]  r_lat_reg;

  logic        w_is_mem;
  logic        w_aligned;
  logic        w_stall;
  logic        w_timeout;

  assign w_is_mem  = (in_operation == OP_LW) || (in_operation == OP_SW);
  assign w_aligned = (in_alu_result[1:0] == 2'b00);
  assign stall     = w_stall;

  // Upstream hold request; r_done marks the replay cycle of a retired memory op
  always_comb begin
    w_stall = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!r_done && w_is_mem && w_aligned) begin
          w_stall = 1'b1;
        end else begin
          w_stall = 1'b0;
        end
      end
      S_ISSUE: w_stall = 1'b1;
      S_WAIT:  w_stall = 1'b1;
      default: w_stall = 1'b1;
    endcase
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int unsigned     CW   = $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 32'd1);

  logic [CW-1:0] r_count;

  assign w_timeout = (r_count == LAST) && !mem_ack;

  // Cycles spent waiting for ack in the current transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_state == S_IDLE) begin
      r_count <= '0;
    end else if (!mem_ack && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end
`else
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES == 32'd0);
`endif

  // Stage state machine with registered bus and writeback outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_lat_en   <= 1'b0;
      r_lat_reg  <= 5'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      wb_value   <= 32'd0;
      wb_enable  <= 1'b0;
      wb_reg     <= 5'd0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      wb_enable  <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (r_done) begin
            r_state <= S_IDLE;
          end else if (w_is_mem && w_aligned) begin
            mem_req   <= 1'b1;
            mem_we    <= (in_operation == OP_SW);
            mem_addr  <= in_alu_result;
            mem_wdata <= in_store_data;
            r_lat_en  <= in_dest_enable;
            r_lat_reg <= in_dest_reg;
            r_state   <= S_ISSUE;
          end else if (w_is_mem) begin
            misaligned <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            wb_value  <= in_alu_result;
            wb_reg    <= in_dest_reg;
            wb_enable <= in_dest_enable && (in_dest_reg != 5'd0);
            r_state   <= S_IDLE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            if (!mem_we) begin
              wb_value  <= mem_rdata;
              wb_reg    <= r_lat_reg;
              wb_enable <= r_lat_en && (r_lat_reg != 5'd0);
            end else begin
              wb_enable <= 1'b0;
            end
          end else if (w_timeout) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          mem_req <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, directed multi-cycle sequences and a randomized run against an
// instruction-level reference model for mem_stage.
module tb_mem_stage;

  localparam logic [4:0] OP_LW = 5'd20;
  localparam logic [4:0] OP_SW = 5'd21;
  localparam int         TMO   = 4;
  localparam int         NV    = 9;
  localparam int         NR    = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_alu_result, in_store_data, mem_rdata;
  logic        in_dest_enable, mem_ack;
  logic [4:0]  in_dest_reg, in_operation;
  logic        stall, mem_req, mem_we, wb_enable, misaligned, bus_error;
  logic [31:0] mem_addr, mem_wdata, wb_value;
  logic [4:0]  wb_reg;

  mem_stage #(.OP_LW(OP_LW), .OP_SW(OP_SW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_alu_result(in_alu_result), .in_dest_enable(in_dest_enable),
    .in_dest_reg(in_dest_reg), .in_operation(in_operation), .in_store_data(in_store_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_value(wb_value), .wb_enable(wb_enable), .wb_reg(wb_reg),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic        en;
    logic [4:0]  rg;
    logic [4:0]  op;
    logic        exp_en;
    logic        exp_mis;
  } vec_t;

  typedef struct packed {
    logic [31:0] alu;
    logic        en;
    logic [4:0]  rg;
    logic [4:0]  op;
    logic [31:0] sd;
  } instr_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic en, input logic [4:0] rg,
                       input logic [4:0] op, input logic [31:0] sd);
    in_alu_result  = alu;
    in_dest_enable = en;
    in_dest_reg    = rg;
    in_operation   = op;
    in_store_data  = sd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb"},    {24'd0, wb_value, wb_enable, wb_reg, misaligned, bus_error}, 64'd0);
    chk({tag, "_mem"},   {30'd0, mem_req, mem_we, mem_addr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
  endtask

  vec_t        v [NV];
  instr_t      prog [$];
  logic [36:0] exp_wb [$];
  logic [64:0] exp_req [$];
  logic [31:0] mem_env [16];
  logic [31:0] mem_ref [16];
  int          exp_mis, seen_mis, k, cyc, tail, txn_wait;
  bit          adv, txn_open, txn_acked;
  logic [31:0] txn_addr;
  instr_t      t;
  int          sel;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
    drive(32'd0, 1'b0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_stall", {63'd0, stall}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // single-cycle IDLE vectors: pass-through ops and misaligned memory ops
    v[0] = '{32'h0000_002A, 1'b1, 5'd5,  5'd0,  1'b1, 1'b0};
    v[1] = '{32'h0000_002A, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0};
    v[2] = '{32'hFFFF_FFFF, 1'b0, 5'd9,  5'd3,  1'b0, 1'b0};
    v[3] = '{32'h8000_0001, 1'b1, 5'd31, 5'd19, 1'b1, 1'b0};
    v[4] = '{32'h0000_1234, 1'b1, 5'd1,  5'd22, 1'b1, 1'b0};
    v[5] = '{32'h0000_0102, 1'b1, 5'd7,  OP_LW, 1'b0, 1'b1};
    v[6] = '{32'h0000_0203, 1'b1, 5'd3,  OP_SW, 1'b0, 1'b1};
    v[7] = '{32'h0000_0101, 1'b0, 5'd0,  OP_SW, 1'b0, 1'b1};
    v[8] = '{32'hCAFE_F00D, 1'b1, 5'd17, 5'd31, 1'b1, 1'b0};
    for (int i = 0; i < NV; i++) begin
      drive(v[i].alu, v[i].en, v[i].rg, v[i].op, 32'h5A5A_0000 + 32'(i));
      #1 chk("tbl_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      chk("tbl_wb_enable", {63'd0, wb_enable}, {63'd0, v[i].exp_en});
      chk("tbl_misaligned", {63'd0, misaligned}, {63'd0, v[i].exp_mis});
      chk("tbl_mem_req", {63'd0, mem_req}, 64'd0);
      if (!v[i].exp_mis) begin
        chk("tbl_wb_value", {32'd0, wb_value}, {32'd0, v[i].alu});
        chk("tbl_wb_reg", {59'd0, wb_reg}, {59'd0, v[i].rg});
      end
    end
    drive(32'd0, 1'b0, 5'd0, 5'd0, 32'd0);

    // load at 0x100, ack two cycles after the request appears
    @(negedge clk);
    drive(32'h0000_0100, 1'b1, 5'd7, OP_LW, 32'd0);
    #1 chk("ld_stall_accept", {63'd0, stall}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ld_req", {30'd0, mem_req, mem_we, mem_addr}, {30'd0, 1'b1, 1'b0, 32'h0000_0100});
      chk("ld_stall_wait", {62'd0, stall, wb_enable}, {62'd0, 1'b1, 1'b0});
      if (c == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'd0;
    chk("ld_wb", {26'd0, wb_enable, wb_reg, wb_value}, {26'd0, 1'b1, 5'd7, 32'hDEAD_BEEF});
    chk("ld_after_ack", {62'd0, mem_req, stall}, 64'd0);
    @(negedge clk);
    chk("ld_no_replay", {62'd0, mem_req, wb_enable}, 64'd0);
    drive(32'd0, 1'b0, 5'd0, 5'd0, 32'd0);

    // store at 0x204 with ack in the first request cycle
    @(negedge clk);
    drive(32'h0000_0204, 1'b1, 5'd3, OP_SW, 32'h1234_5678);
    #1 chk("st_stall_accept", {63'd0, stall}, 64'd1);
    @(negedge clk);
    chk("st_req", {30'd0, mem_req, mem_we, mem_addr}, {30'd0, 1'b1, 1'b1, 32'h0000_0204});
    chk("st_wdata", {32'd0, mem_wdata}, {32'd0, 32'h1234_5678});
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("st_after_ack", {61'd0, mem_req, wb_enable, stall}, 64'd0);
    @(negedge clk);
    chk("st_no_wb", {62'd0, mem_req, wb_enable}, 64'd0);
    drive(32'd0, 1'b0, 5'd0, 5'd0, 32'd0);

    // reset while waiting for ack, then stray acks in IDLE
    @(negedge clk);
    drive(32'h0000_0100, 1'b1, 5'd9, OP_LW, 32'd0);
    @(negedge clk);
    chk("rst_seq_issue", {63'd0, mem_req}, 64'd1);
    @(negedge clk);
    chk("rst_seq_wait", {63'd0, mem_req}, 64'd1);
    reset = 1'b1;
    drive(32'd0, 1'b0, 5'd0, 5'd0, 32'd0);
    #1 chk_all_zero("rst_mid");
    chk("rst_mid_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_nowb", {62'd0, mem_req, wb_enable}, 64'd0);
    drive(32'h0000_0099, 1'b1, 5'd6, 5'd0, 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'd0;
    chk("stray_ack_pass", {26'd0, wb_enable, wb_reg, wb_value}, {26'd0, 1'b1, 5'd6, 32'h0000_0099});
    chk("stray_ack_req", {63'd0, mem_req}, 64'd0);
    drive(32'd0, 1'b0, 5'd0, 5'd0, 32'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // load that never gets an ack
    @(negedge clk);
    drive(32'h0000_0108, 1'b1, 5'd2, OP_LW, 32'd0);
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      chk("tmo_waiting", {62'd0, mem_req, bus_error}, {62'd0, 1'b1, 1'b0});
    end
    @(negedge clk);
    chk("tmo_pulse", {60'd0, bus_error, mem_req, wb_enable, stall}, {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk("tmo_after", {61'd0, bus_error, mem_req, wb_enable}, 64'd0);
    drive(32'd0, 1'b0, 5'd0, 5'd0, 32'd0);
`endif

    // randomized program against an instruction-order reference model
    for (int i = 0; i < 16; i++) begin
      mem_env[i] = $urandom;
      mem_ref[i] = mem_env[i];
    end
    exp_mis = 0;
    for (int i = 0; i < NR; i++) begin
      sel   = int'($urandom_range(0, 9));
      t.en  = ($urandom_range(0, 3) != 0);
      t.rg  = 5'($urandom_range(0, 31));
      t.sd  = $urandom;
      if (sel < 4) t.op = OP_LW;
      else if (sel < 7) t.op = OP_SW;
      else begin
        do t.op = 5'($urandom_range(0, 31)); while (t.op == OP_LW || t.op == OP_SW);
      end
      if (t.op == OP_LW || t.op == OP_SW) begin
        t.alu = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 7) == 0) t.alu = t.alu + 32'($urandom_range(1, 3));
        if (t.alu[1:0] != 2'b00) exp_mis++;
        else if (t.op == OP_LW) begin
          exp_req.push_back({1'b0, t.alu, 32'd0});
          if (t.en && t.rg != 5'd0) exp_wb.push_back({t.rg, mem_ref[t.alu[5:2]]});
        end else begin
          exp_req.push_back({1'b1, t.alu, t.sd});
          mem_ref[t.alu[5:2]] = t.sd;
        end
      end else begin
        t.alu = $urandom;
        if (t.en && t.rg != 5'd0) exp_wb.push_back({t.rg, t.alu});
      end
      prog.push_back(t);
    end

    @(negedge clk);
    k = 0; cyc = 0; tail = 0; seen_mis = 0;
    txn_open = 1'b0; txn_acked = 1'b0; txn_wait = 0; txn_addr = 32'd0;
    drive(prog[0].alu, prog[0].en, prog[0].rg, prog[0].op, prog[0].sd);
    #1 adv = !stall;
    while (tail < 8 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      chk("rnd_bus_error", {63'd0, bus_error}, 64'd0);
      if (misaligned) seen_mis++;
      if (wb_enable) begin
        if (exp_wb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rnd_wb_extra: got reg %0d value %h, expected no writeback", wb_reg, wb_value);
        end else begin
          chk("rnd_wb", {27'd0, wb_reg, wb_value}, {27'd0, exp_wb.pop_front()});
        end
      end
      mem_ack = 1'b0; mem_rdata = 32'd0;
      if (mem_req) begin
        if (!txn_open) begin
          txn_open = 1'b1; txn_acked = 1'b0; txn_addr = mem_addr;
          txn_wait = int'($urandom_range(0, 3));
        end else begin
          chk("rnd_addr_stable", {32'd0, mem_addr}, {32'd0, txn_addr});
        end
        if (!txn_acked) begin
          if (txn_wait == 0) begin
            txn_acked = 1'b1; mem_ack = 1'b1;
            if (exp_req.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL rnd_req_extra: got addr %h we %b, expected no request", mem_addr, mem_we);
            end else begin
              chk("rnd_req", {mem_we, mem_addr, (mem_we ? mem_wdata : 32'd0)}, exp_req.pop_front());
            end
            if (mem_we) mem_env[mem_addr[5:2]] = mem_wdata;
            else mem_rdata = mem_env[mem_addr[5:2]];
          end else begin
            txn_wait--;
          end
        end
      end else begin
        txn_open = 1'b0;
      end
      if (adv) begin
        k++;
        if (k < NR) drive(prog[k].alu, prog[k].en, prog[k].rg, prog[k].op, prog[k].sd);
        else drive(32'd0, 1'b0, 5'd0, 5'd0, 32'd0);
      end
      if (k >= NR) tail++;
      #1 adv = !stall;
    end
    mem_ack = 1'b0;
    if (cyc >= 20000) begin
      n_vec++; n_err++;
      $display("FAIL rnd_budget: got %0d instructions consumed, expected %0d", k, NR);
    end
    chk("rnd_misaligned_count", 64'(seen_mis), 64'(exp_mis));
    chk("rnd_wb_left", 64'(exp_wb.size()), 64'd0);
    chk("rnd_req_left", 64'(exp_req.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
